// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic addr_t align_word(input addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with extra-MSB pointers; flush beats push/pop, and storage resets to RESET_VAL
// so the head outputs have defined values before the first push.
module fetch_fifo #(
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= RESET_VAL;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: one outstanding imem read, redirect flush, optional stall
// counter enabled by macro FETCH_STATS_EN.
//   state | meaning
//   IDLE  | no request; waits for a free queue slot
//   REQ   | request pending at imem_addr; ack data is queued
//   DROP  | request pending but stale; ack data dropped, then fetch from redir_pc
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter addr_t       RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  addr_t         redir_pc;
  logic [CW-1:0] count;
  logic          empty;
  logic          pop;
  logic          push;
  logic [63:0]   head;

  assign instr_valid    = !empty;
  assign pop            = instr_valid && instr_ready && !redirect;
  assign push           = (state == REQ) && imem_ack && !redirect;
  assign instr_out      = head[63:32];
  assign instr_pc       = head[31:0];
  assign instr_pc_plus4 = instr_pc + 32'(WORD_BYTES);

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (64),
    .RESET_VAL({32'h0, RESET_PC})
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect),
    .push (push),
    .pop  (pop),
    .wdata({imem_rdata, imem_addr}),
    .rdata(head),
    .empty(empty),
    .count(count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      redir_pc  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            imem_addr <= align_word(redirect_pc);
            state     <= REQ;
            imem_req  <= 1'b1;
          end else if (count < CW'(DEPTH) || pop) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (redirect) begin
            if (imem_ack) begin
              imem_addr <= align_word(redirect_pc);
            end else begin
              redir_pc <= align_word(redirect_pc);
              state    <= DROP;
            end
          end else if (imem_ack) begin
            imem_addr <= imem_addr + 32'(WORD_BYTES);
            // Keep fetching only if a slot remains after this push.
            if (!(pop || count < CW'(DEPTH - 1))) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            imem_addr <= redirect ? align_word(redirect_pc) : redir_pc;
            state     <= REQ;
          end else if (redirect) begin
            redir_pc <= align_word(redirect_pc);
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (imem_req && !imem_ack && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue; stall counter checks need FETCH_STATS_EN.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_count;
`endif

  logic        rst_w;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        imem_ack_w;
  logic [31:0] imem_rdata_w;
  logic        instr_valid_w;
  logic        instr_ready_w;
  logic [31:0] instr_out_w;
  logic [31:0] instr_pc_w;
  logic [31:0] instr_pc_plus4_w;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_count_w;
`endif

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
`ifdef FETCH_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w),
    .imem_rdata(imem_rdata_w), .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid_w), .instr_ready(instr_ready_w), .instr_out(instr_out_w),
    .instr_pc(instr_pc_w), .instr_pc_plus4(instr_pc_plus4_w)
`ifdef FETCH_STATS_EN
    , .stall_count(stall_count_w)
`endif
  );

  assign imem_rdata_w = mem_word(imem_addr_w);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; redirect = 1'b0; instr_ready = 1'b1; imem_rdata = 32'h1111_2222;
    step(); step();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
    n_vec++; if (instr_out !== 32'h0) begin n_err++; $display("FAIL rst_out: got %h want 00000000", instr_out); end
    n_vec++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 00000000", instr_pc); end
    n_vec++; if (instr_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_pc4: got %h want 00000004", instr_pc_plus4); end
    imem_ack = 1'b0; instr_ready = 1'b0;
    rst = 1'b0;
    step();
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    instr_ready = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 32'(i) * 32'd4;
      n_vec++; if (imem_addr !== a) begin n_err++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_addr, a); end
      imem_rdata = mem_word(a);
      step();
      n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, instr_valid); end
      n_vec++; if (instr_pc !== a) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", i, instr_pc, a); end
      n_vec++; if (instr_out !== mem_word(a)) begin n_err++; $display("FAIL stream_out[%0d]: got %h want %h", i, instr_out, mem_word(a)); end
      n_vec++; if (instr_pc_plus4 !== a + 32'd4) begin n_err++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, instr_pc_plus4, a + 32'd4); end
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] a;
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i) * 32'd4;
      n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL full_req[%0d]: got %b want 1", i, imem_req); end
      n_vec++; if (imem_addr !== a) begin n_err++; $display("FAIL full_addr[%0d]: got %h want %h", i, imem_addr, a); end
      imem_rdata = mem_word(a);
      step();
    end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL full_stop: got %b want 0", imem_req); end
    imem_rdata = 32'hBAD0_BAD0;
    step(); step();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL full_idle_ack: got %b want 0", imem_req); end
    n_vec++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL full_head: got %h want 00000000", instr_pc); end
    imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL refill_req: got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL refill_addr: got %h want 00000010", imem_addr); end
    n_vec++; if (instr_pc !== 32'h4) begin n_err++; $display("FAIL refill_head: got %h want 00000004", instr_pc); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0); step();
    imem_rdata = mem_word(32'h4); step();
    imem_ack = 1'b0;
    n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL pre_redir_valid: got %b want 1", instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h0000_0180; step();
    redirect = 1'b0;
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL drop_req: got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL drop_addr: got %h want 00000008", imem_addr); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL drop_flush: got %b want 0", instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103; step();
    redirect = 1'b0;
    n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL drop_hold: got %h want 00000008", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step();
    imem_ack = 1'b0;
    n_vec++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL drop_newaddr: got %h want 00000100", imem_addr); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL drop_discard: got %b want 0", instr_valid); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h100); step();
    imem_ack = 1'b0;
    n_vec++; if (instr_pc !== 32'h100) begin n_err++; $display("FAIL drop_pc: got %h want 00000100", instr_pc); end
    n_vec++; if (instr_out !== mem_word(32'h100)) begin n_err++; $display("FAIL drop_out: got %h want %h", instr_out, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    instr_ready = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(32'h0); step();
    redirect = 1'b1; redirect_pc = 32'h200; imem_rdata = mem_word(32'h4); step();
    redirect = 1'b0; imem_ack = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rap_valid: got %b want 0", instr_valid); end
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rap_req: got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL rap_addr: got %h want 00000200", imem_addr); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h200); step();
    imem_ack = 1'b0; instr_ready = 1'b0;
    n_vec++; if (instr_pc !== 32'h200) begin n_err++; $display("FAIL rap_pc: got %h want 00000200", instr_pc); end
    n_vec++; if (instr_pc_plus4 !== 32'h204) begin n_err++; $display("FAIL rap_pc4: got %h want 00000204", instr_pc_plus4); end
  endtask

  task automatic test_wrap();
    rst_w = 1'b1; step(); step();
    rst_w = 1'b0; step();
    n_vec++; if (imem_addr_w !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_addr0: got %h want fffffff8", imem_addr_w); end
    step();
    n_vec++; if (imem_addr_w !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr1: got %h want fffffffc", imem_addr_w); end
    n_vec++; if (instr_pc_w !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_pc0: got %h want fffffff8", instr_pc_w); end
    n_vec++; if (instr_out_w !== mem_word(32'hFFFF_FFF8)) begin n_err++; $display("FAIL wrap_out0: got %h want %h", instr_out_w, mem_word(32'hFFFF_FFF8)); end
    step();
    n_vec++; if (imem_addr_w !== 32'h0) begin n_err++; $display("FAIL wrap_addr2: got %h want 00000000", imem_addr_w); end
    n_vec++; if (instr_pc_w !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc1: got %h want fffffffc", instr_pc_w); end
    n_vec++; if (instr_pc_plus4_w !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want 00000000", instr_pc_plus4_w); end
    step();
    n_vec++; if (instr_pc_w !== 32'h0) begin n_err++; $display("FAIL wrap_pc2: got %h want 00000000", instr_pc_w); end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stall();
    do_reset();
    n_vec++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL stall_init: got %0d want 0", stall_count); end
    for (int i = 0; i < 5; i++) step();
    n_vec++; if (stall_count !== 32'd5) begin n_err++; $display("FAIL stall_5: got %0d want 5", stall_count); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0); step();
    imem_ack = 1'b0;
    n_vec++; if (stall_count !== 32'd5) begin n_err++; $display("FAIL stall_ack: got %0d want 5", stall_count); end
    rst = 1'b1; step();
    n_vec++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL stall_rst: got %0d want 0", stall_count); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    rst_w = 1'b1; imem_ack_w = 1'b1; instr_ready_w = 1'b1;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_wrap();
`ifdef FETCH_STATS_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
